fetch_wait_ctrl: RTL and testbench

//  Memory-side responder to the CPU sequencer's fetch phase. While fetch_en is high, runs one

---
 rtl/fetch_wait_ctrl_pkg.sv | 18 +
 rtl/fetch_wait_ctrl_wait_counter.sv | 46 ++++
 rtl/fetch_wait_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fetch_wait_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_wait_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_wait_ctrl_pkg
//   Shared definitions for the instruction-fetch wait controller:
//   FSM state encodings, counter widths and the default NOP instruction word.
// -----------------------------------------------------------------------------
package fetch_wait_ctrl_pkg;

  typedef enum logic [1:0] {
    FW_IDLE   = 2'd0,
    FW_ACCESS = 2'd1,
    FW_DONE   = 2'd2
  } fw_state_e;

  localparam int          FW_CNT_W     = 4;   // wait-state counter width
  localparam int          FW_TMR_W     = 8;   // timeout timer width
  localparam logic [15:0] FW_NOP_INSTR = 16'h0000;

endpackage

// File: rtl/fetch_wait_ctrl_wait_counter.sv
// -----------------------------------------------------------------------------
// wait_counter
//   Loadable up-counter that saturates at MAX and flags terminal count.
//   Ports:
//     clk  in  system clock, rising edge
//     rst  in  asynchronous reset, active-high (count -> 0)
//     load in  clear the count to zero (has priority over inc)
//     inc  in  advance the count by one, holding at MAX
//     tc   out count has reached MAX
// -----------------------------------------------------------------------------
module wait_counter
  import fetch_wait_ctrl_pkg::*;
#(
  parameter int           W   = FW_CNT_W,
  parameter logic [W-1:0] MAX = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == MAX);

endmodule

// File: rtl/fetch_wait_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_wait_ctrl
//   Memory-side responder to the CPU sequencer's fetch phase. Runs one
//   instruction read per fetch, inserts WAIT_STATES access cycles before
//   mem_ready is honoured, and stalls the sequencer via needWait until the
//   word is latched.
//
//   Optional feature macro: FETCH_TIMEOUT_EN
//     defined   : an 8-bit timer aborts an ACCESS lasting TIMEOUT cycles,
//                 delivers NOP_INSTR and sets the sticky fetch_err flag.
//     undefined : ACCESS waits indefinitely; fetch_err is tied 0.
//
//   Ports:
//     clk       in   system clock, rising edge
//     rst       in   asynchronous reset, active-high
//     fetch_en  in   sequencer is in its fetch phase
//     pc        in   fetch address, sampled when leaving IDLE
//     needWait  out  stall request to the sequencer (combinational)
//     mem_rd    out  memory read strobe
//     mem_addr  out  latched fetch address
//     mem_rdata in   memory read data
//     mem_ready in   memory data valid this cycle
//     instr     out  last fetched instruction
//     fetch_err out  sticky timeout flag
// -----------------------------------------------------------------------------
module fetch_wait_ctrl
  import fetch_wait_ctrl_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 16,
  parameter int                WAIT_STATES = 2,
  parameter int                TIMEOUT     = 64,
  parameter logic [DATA_W-1:0] NOP_INSTR   = DATA_W'(FW_NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc,
  output logic              needWait,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] instr,
  output logic              fetch_err
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("fetch_wait_ctrl: WAIT_STATES must be within 0..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 256) begin : g_bad_timeout
    $error("fetch_wait_ctrl: TIMEOUT must be within 1..256");
  end

  fw_state_e         state_q,    state_d;
  logic              mem_rd_q,   mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] instr_q,    instr_d;
  logic              fetch_err_q, fetch_err_d;

  logic cnt_load;
  logic cnt_inc;
  logic cnt_tc;

  // Access wait-state counter: cleared on fetch start, counts ACCESS cycles.
  wait_counter #(
    .W   (FW_CNT_W),
    .MAX (FW_CNT_W'(WAIT_STATES))
  ) u_wait_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .inc  (cnt_inc),
    .tc   (cnt_tc)
  );

`ifdef FETCH_TIMEOUT_EN
  logic tmr_tc;

  // Timeout timer shares load/inc with the wait counter; terminal count is
  // reached on the TIMEOUT-th ACCESS cycle.
  wait_counter #(
    .W   (FW_TMR_W),
    .MAX (FW_TMR_W'(TIMEOUT - 1))
  ) u_timeout_tmr (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .inc  (cnt_inc),
    .tc   (tmr_tc)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{NOP_INSTR, TIMEOUT};
`endif

  always_comb begin
    state_d     = state_q;
    mem_rd_d    = mem_rd_q;
    mem_addr_d  = mem_addr_q;
    instr_d     = instr_q;
    fetch_err_d = fetch_err_q;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;

    case (state_q)
      FW_IDLE: begin
        if (fetch_en) begin
          mem_addr_d = pc;
          cnt_load   = 1'b1;
          mem_rd_d   = 1'b1;
          state_d    = FW_ACCESS;
        end
      end

      FW_ACCESS: begin
        cnt_inc = 1'b1;
        // The sequencer leaving fetch aborts the access without capture.
        if (!fetch_en) begin
          mem_rd_d = 1'b0;
          state_d  = FW_IDLE;
        end else if (cnt_tc && mem_ready) begin
          instr_d  = mem_rdata;
          mem_rd_d = 1'b0;
          state_d  = FW_DONE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmr_tc) begin
          instr_d     = NOP_INSTR;
          fetch_err_d = 1'b1;
          mem_rd_d    = 1'b0;
          state_d     = FW_DONE;
        end
`endif
      end

      FW_DONE: begin
        mem_rd_d = 1'b0;
        state_d  = FW_IDLE;
      end

      // Unused encoding 2'd3 recovers to IDLE.
      default: begin
        mem_rd_d = 1'b0;
        state_d  = FW_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FW_IDLE;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      instr_q     <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      instr_q     <= instr_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Combinational so the sequencer stalls already in the IDLE cycle.
  assign needWait  = fetch_en & (state_q != FW_DONE);
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign instr     = instr_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_wait_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_wait_ctrl
//   Two controller instances (WAIT_STATES=2 and WAIT_STATES=0, TIMEOUT=8)
//   checked every cycle against a transaction-level model, plus directed
//   scenarios with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_fetch_wait_ctrl;

  localparam int          TMO = 8;
  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fe    [2];
  logic [15:0] pcv   [2];
  logic [15:0] rdat  [2];
  logic        rdy   [2];
  logic        nw    [2];
  logic        mrd   [2];
  logic        ferr  [2];
  logic [15:0] maddr [2];
  logic [15:0] ins   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_wait_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(2), .TIMEOUT(TMO),
                    .NOP_INSTR(NOP)) dut_a (
    .clk(clk), .rst(rst), .fetch_en(fe[0]), .pc(pcv[0]), .needWait(nw[0]),
    .mem_rd(mrd[0]), .mem_addr(maddr[0]), .mem_rdata(rdat[0]),
    .mem_ready(rdy[0]), .instr(ins[0]), .fetch_err(ferr[0]));

  fetch_wait_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(0), .TIMEOUT(TMO),
                    .NOP_INSTR(NOP)) dut_b (
    .clk(clk), .rst(rst), .fetch_en(fe[1]), .pc(pcv[1]), .needWait(nw[1]),
    .mem_rd(mrd[1]), .mem_addr(maddr[1]), .mem_rdata(rdat[1]),
    .mem_ready(rdy[1]), .instr(ins[1]), .fetch_err(ferr[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ws_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // Transaction-level model: a fetch is "open" from acceptance until it is
  // captured, aborted or timed out; m_acc counts completed access cycles.
  bit          m_open [2];
  bit          m_done [2];
  bit          m_rd   [2];
  bit          m_err  [2];
  int          m_acc  [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_ins  [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_open[i] <= 1'b0; m_done[i] <= 1'b0; m_rd[i] <= 1'b0; m_err[i] <= 1'b0;
        m_acc[i]  <= 0;    m_addr[i] <= '0;   m_ins[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_done[i]) begin
          m_done[i] <= 1'b0;
        end else if (!m_open[i]) begin
          if (fe[i]) begin
            m_open[i] <= 1'b1; m_acc[i] <= 0; m_addr[i] <= pcv[i]; m_rd[i] <= 1'b1;
          end
        end else if (!fe[i]) begin
          m_open[i] <= 1'b0; m_rd[i] <= 1'b0;
        end else if (m_acc[i] >= ws_of(i) && rdy[i]) begin
          m_ins[i] <= rdat[i]; m_open[i] <= 1'b0; m_done[i] <= 1'b1; m_rd[i] <= 1'b0;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (m_acc[i] + 1 >= TMO) begin
          m_ins[i] <= NOP; m_err[i] <= 1'b1;
          m_open[i] <= 1'b0; m_done[i] <= 1'b1; m_rd[i] <= 1'b0;
        end
`endif
        else begin
          m_acc[i] <= m_acc[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("needWait[%0d]", i), 32'(nw[i]),  32'(fe[i] && !m_done[i]));
      check($sformatf("mem_rd[%0d]", i),   32'(mrd[i]), 32'(m_rd[i]));
      check($sformatf("mem_addr[%0d]", i), 32'(maddr[i]), 32'(m_addr[i]));
      check($sformatf("instr[%0d]", i),    32'(ins[i]),  32'(m_ins[i]));
      check($sformatf("fetch_err[%0d]", i), 32'(ferr[i]), 32'(m_err[i]));
    end
  end

  // Starts a fetch on instance i; mem_ready stays low for the first rdy_low
  // access cycles. Returns the number of cycles needWait was high. Leaves the
  // bench at the negedge of the first needWait-low cycle.
  task automatic do_fetch(input int i, input logic [15:0] a, input logic [15:0] d,
                          input int rdy_low, output int hi);
    bit seen_low = 1'b0;
    hi = 0;
    @(posedge clk); #1;
    fe[i] = 1'b1; pcv[i] = a; rdat[i] = d;
    for (int c = 0; c < 300; c++) begin
      rdy[i] = (c > rdy_low);
      @(negedge clk);
      if (nw[i]) hi++;
      else begin seen_low = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!seen_low) begin
      checks++; errors++;
      $display("FAIL fetch_timeout[%0d]: needWait never dropped, got %0d cycles, expected release", i, hi);
      @(posedge clk); #1; fe[i] = 1'b0;
    end
  endtask

  task automatic release_fe(input int i);
    @(posedge clk); #1;
    fe[i] = 1'b0; rdy[i] = 1'b0;
  endtask

  initial begin
    int hi;
    int caps;
    int cyc;
    logic [15:0] prev;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fe[i] = 1'b0; pcv[i] = '0; rdat[i] = '0; rdy[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mem_rd", 32'(mrd[0]), 32'd0);
    check("reset_instr",  32'(ins[0]), 32'd0);
    check("reset_addr",   32'(maddr[0]), 32'd0);
    check("reset_err",    32'(ferr[0]), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // WAIT_STATES=2, ready tied high: 4 stall cycles then 1 low.
    do_fetch(0, 16'h0040, 16'hBEEF, 0, hi);
    check("t2_stall_cycles", 32'(hi), 32'd4);
    check("t2_mem_addr", 32'(maddr[0]), 32'h0040);
    check("t2_instr",    32'(ins[0]),   32'hBEEF);
    check("t2_mem_rd_done", 32'(mrd[0]), 32'd0);
    release_fe(0);

    // Async reset in the middle of ACCESS.
    @(posedge clk); #1;
    fe[0] = 1'b1; pcv[0] = 16'h0123; rdy[0] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_mem_rd_before", 32'(mrd[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t1_mem_rd",   32'(mrd[0]), 32'd0);
    check("t1_needWait", 32'(nw[0]),  32'd1);
    check("t1_instr",    32'(ins[0]), 32'd0);
    check("t1_mem_addr", 32'(maddr[0]), 32'd0);
    @(posedge clk); #1; fe[0] = 1'b0;
    @(posedge clk); #1; rst = 1'b0;

    // Back-to-back fetches under a sequencer that advances when needWait=0.
    @(posedge clk); #1;
    fe[0] = 1'b1; pcv[0] = 16'h0001; rdat[0] = 16'h1111; rdy[0] = 1'b1;
    caps = 0; cyc = 0;
    while (caps < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!nw[0]) begin
        caps++;
        check($sformatf("t5_instr%0d", caps), 32'(ins[0]),
              (caps == 1) ? 32'h1111 : 32'h2222);
        check($sformatf("t5_addr%0d", caps), 32'(maddr[0]), 32'(caps));
        @(posedge clk); #1;
        pcv[0] = 16'h0002; rdat[0] = 16'h2222;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("t5_captures", 32'(caps), 32'd2);
    check("t5_cycles",   32'(cyc),  32'd10);
    fe[0] = 1'b0; rdy[0] = 1'b0;

    // Abort: fetch_en dropped in the second ACCESS cycle.
    prev = ins[0];
    @(posedge clk); #1;
    fe[0] = 1'b1; pcv[0] = 16'h0077; rdat[0] = 16'hDEAD; rdy[0] = 1'b0;
    @(posedge clk); #1;           // ACCESS 1
    @(posedge clk); #1;           // ACCESS 2
    fe[0] = 1'b0;
    @(negedge clk);
    check("t4_mem_rd_access2", 32'(mrd[0]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_mem_rd_after", 32'(mrd[0]), 32'd0);
    check("t4_instr_kept",   32'(ins[0]), 32'(prev));
    check("t4_instr_literal", 32'(ins[0]), 32'h2222);

    // WAIT_STATES=0, ready low 5 access cycles: 7 stall cycles.
    do_fetch(1, 16'h0abc, 16'h5A5A, 5, hi);
    check("t3_stall_cycles", 32'(hi), 32'd7);
    check("t3_instr", 32'(ins[1]), 32'h5A5A);
    check("t3_addr",  32'(maddr[1]), 32'h0abc);
    release_fe(1);

`ifdef FETCH_TIMEOUT_EN
    // Timeout after 8 access cycles, then a good fetch keeps the error flag.
    do_fetch(0, 16'h0100, 16'hCAFE, 1000, hi);
    check("t6_stall_cycles", 32'(hi), 32'd9);
    check("t6_instr_nop", 32'(ins[0]), 32'(NOP));
    check("t6_err", 32'(ferr[0]), 32'd1);
    release_fe(0);
    do_fetch(0, 16'h0200, 16'h7777, 0, hi);
    check("t6_good_stall", 32'(hi), 32'd4);
    check("t6_good_instr", 32'(ins[0]), 32'h7777);
    check("t6_err_sticky", 32'(ferr[0]), 32'd1);
    release_fe(0);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
